// File: rtl/serial_word_collector.sv
// Assembles WIDTH serial bits from one channel into a tagged word with valid/ready output.
// Optional SWC_DROP_CNT_EN adds a saturating counter of bits dropped while a word waits.
module serial_word_collector #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic [1:0]       chan,
   output logic [WIDTH-1:0] word_out,
   output logic [1:0]       chan_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic             chan_err
`ifdef SWC_DROP_CNT_EN
   ,
   output logic [7:0]       drop_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [4:0] WIDTH_C = 5'(WIDTH);

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [1:0]       fchan_q, fchan_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [1:0]       chan_out_q, chan_out_d;
   logic             valid_q;
   logic             busy_q;
   logic             err_q, err_d;

   // Direction is chosen so the first bit of a frame ends at the documented word end.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
      if (MSB_FIRST) begin
         return {base[WIDTH-2:0], b};
      end else begin
         return {b, base[WIDTH-1:1]};
      end
   endfunction

   // Next-state, shift register and word capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      fchan_d    = fchan_q;
      word_d     = word_q;
      chan_out_d = chan_out_q;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bit_valid) begin
               fchan_d = chan;
               shreg_d = shift_in({WIDTH{1'b0}}, bit_in);
               cnt_d   = 5'd1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (bit_valid && (chan == fchan_q)) begin
               if ((cnt_q + 5'd1) == WIDTH_C) begin
                  word_d     = shift_in(shreg_q, bit_in);
                  chan_out_d = fchan_q;
                  cnt_d      = 5'd0;
                  state_d    = HOLD;
               end else begin
                  shreg_d = shift_in(shreg_q, bit_in);
                  cnt_d   = cnt_q + 5'd1;
               end
            end else if (bit_valid) begin
               // Channel switched mid-frame: this bit opens a fresh frame.
               err_d   = 1'b1;
               fchan_d = chan;
               shreg_d = shift_in({WIDTH{1'b0}}, bit_in);
               cnt_d   = 5'd1;
            end else begin
               state_d = SHIFT;
            end
         end
         HOLD: begin
            if (word_ready && bit_valid) begin
               fchan_d = chan;
               shreg_d = shift_in({WIDTH{1'b0}}, bit_in);
               cnt_d   = 5'd1;
               state_d = SHIFT;
            end else if (word_ready) begin
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 5'd0;
         shreg_q    <= {WIDTH{1'b0}};
         fchan_q    <= 2'd0;
         word_q     <= {WIDTH{1'b0}};
         chan_out_q <= 2'd0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         fchan_q    <= fchan_d;
         word_q     <= word_d;
         chan_out_q <= chan_out_d;
         valid_q    <= (state_d == HOLD);
         busy_q     <= (state_d == SHIFT);
         err_q      <= err_d;
      end
   end

   assign word_out   = word_q;
   assign chan_out   = chan_out_q;
   assign word_valid = valid_q;
   assign busy       = busy_q;
   assign chan_err   = err_q;

`ifdef SWC_DROP_CNT_EN
   logic [7:0] drop_q;

   // Counts bits refused while a completed word is waiting; saturates.
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_q <= 8'd0;
      end else if ((state_q == HOLD) && bit_valid && !word_ready && (drop_q != 8'd255)) begin
         drop_q <= drop_q + 8'd1;
      end else begin
         drop_q <= drop_q;
      end
   end

   assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Drives an MSB-first and an LSB-first collector with the same stream and compares
// both against a frame-level model built from bit queues.
module tb_serial_word_collector;

   localparam int W = 8;

   logic         clock;
   logic         reset;
   logic         bit_in;
   logic         bit_valid;
   logic [1:0]   chan;
   logic         word_ready;

   logic [W-1:0] wo1, wo0;
   logic [1:0]   co1, co0;
   logic         wv1, wv0, busy1, busy0, err1, err0;
`ifdef SWC_DROP_CNT_EN
   logic [7:0]   dc1, dc0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .chan(chan),
      .word_out(wo1), .chan_out(co1), .word_valid(wv1), .word_ready(word_ready),
      .busy(busy1), .chan_err(err1)
`ifdef SWC_DROP_CNT_EN
      , .drop_cnt(dc1)
`endif
   );

   serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .chan(chan),
      .word_out(wo0), .chan_out(co0), .word_valid(wv0), .word_ready(word_ready),
      .busy(busy0), .chan_err(err0)
`ifdef SWC_DROP_CNT_EN
      , .drop_cnt(dc0)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: the bits of the open frame, and what is on offer downstream.
   logic         m_frame[$];
   logic [1:0]   m_fchan = 2'd0;
   logic         m_hold  = 1'b0;
   logic         m_err   = 1'b0;
   logic [W-1:0] m_w1    = '0;
   logic [W-1:0] m_w0    = '0;
   logic [1:0]   m_chan  = 2'd0;
   int           m_drops = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic bv, input logic b, input logic [1:0] ch,
                        input logic rdy);
      m_err = 1'b0;
      if (r) begin
         m_frame.delete();
         m_hold = 1'b0; m_w1 = '0; m_w0 = '0; m_chan = 2'd0; m_fchan = 2'd0; m_drops = 0;
      end else if (m_hold) begin
         if (rdy) begin
            m_hold = 1'b0;
            if (bv) begin
               m_frame.delete();
               m_frame.push_back(b);
               m_fchan = ch;
            end
         end else if (bv && m_drops < 255) begin
            m_drops++;
         end
      end else if (bv) begin
         if (m_frame.size() != 0 && ch != m_fchan) begin
            m_err = 1'b1;
            m_frame.delete();
         end
         if (m_frame.size() == 0) m_fchan = ch;
         m_frame.push_back(b);
         if (m_frame.size() == W) begin
            for (int i = 0; i < W; i++) begin
               m_w1[W-1-i] = m_frame[i];
               m_w0[i]     = m_frame[i];
            end
            m_chan = m_fchan;
            m_hold = 1'b1;
            m_frame.delete();
         end
      end
   endtask

   task automatic check_all();
      chk("word_out_msb", 32'(wo1), 32'(m_w1));
      chk("word_out_lsb", 32'(wo0), 32'(m_w0));
      chk("chan_out_msb", 32'(co1), 32'(m_chan));
      chk("chan_out_lsb", 32'(co0), 32'(m_chan));
      chk("word_valid_msb", 32'(wv1), 32'(m_hold));
      chk("word_valid_lsb", 32'(wv0), 32'(m_hold));
      chk("busy_msb", 32'(busy1), 32'(m_frame.size() != 0));
      chk("busy_lsb", 32'(busy0), 32'(m_frame.size() != 0));
      chk("chan_err_msb", 32'(err1), 32'(m_err));
      chk("chan_err_lsb", 32'(err0), 32'(m_err));
`ifdef SWC_DROP_CNT_EN
      chk("drop_cnt_msb", 32'(dc1), 32'(m_drops));
      chk("drop_cnt_lsb", 32'(dc0), 32'(m_drops));
`endif
   endtask

   task automatic step(input logic r, input logic bv, input logic b, input logic [1:0] ch,
                       input logic rdy);
      reset = r; bit_valid = bv; bit_in = b; chan = ch; word_ready = rdy;
      @(posedge clock);
      model(r, bv, b, ch, rdy);
      #1;
      check_all();
   endtask

   // Sends the n leading bits of 'bits' (bit 7 first) on one channel.
   task automatic send_bits(input logic [1:0] ch, input logic [7:0] bits, input int n,
                            input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, bits[7-i], ch, rdy);
   endtask

   initial begin
      reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; chan = 2'd0; word_ready = 1'b0;
      step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
      chk("reset_word", 32'(wo1), 32'h0);
      chk("reset_valid", 32'(wv1), 32'h0);

      send_bits(2'd2, 8'hA5, 8, 1'b1);
      chk("a5_word", 32'(wo1), 32'hA5);
      chk("a5_chan", 32'(co1), 32'h2);
      chk("a5_valid", 32'(wv1), 32'h1);
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("a5_valid_drop", 32'(wv1), 32'h0);
      chk("a5_busy", 32'(busy1), 32'h0);

      send_bits(2'd0, 8'hC0, 8, 1'b1);
      chk("c0_msb", 32'(wo1), 32'hC0);
      chk("c0_lsb", 32'(wo0), 32'h03);
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

      send_bits(2'd1, 8'hA0, 3, 1'b1);
      send_bits(2'd3, 8'hF0, 1, 1'b1);
      chk("abort_err", 32'(err1), 32'h1);
      send_bits(2'd3, 8'hE0, 7, 1'b1);
      chk("abort_word", 32'(wo1), 32'hF0);
      chk("abort_chan", 32'(co1), 32'h3);
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

      send_bits(2'd2, 8'h5C, 8, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
      step(1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
      step(1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
      chk("bp_word", 32'(wo1), 32'h5C);
      chk("bp_valid", 32'(wv1), 32'h1);
`ifdef SWC_DROP_CNT_EN
      chk("bp_drops", 32'(dc1), 32'd3);
`endif
      step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
      chk("b2b_busy", 32'(busy1), 32'h1);
      send_bits(2'd1, 8'h34, 7, 1'b1);
      chk("b2b_word", 32'(wo1), 32'h9A);
      chk("b2b_chan", 32'(co1), 32'h1);
`ifdef SWC_DROP_CNT_EN
      chk("b2b_drops", 32'(dc1), 32'd3);
`endif
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

      send_bits(2'd3, 8'hF0, 4, 1'b1);
      step(1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
      chk("rst_busy", 32'(busy1), 32'h0);
      chk("rst_word", 32'(wo1), 32'h0);
      send_bits(2'd2, 8'h3C, 8, 1'b1);
      chk("post_rst_word", 32'(wo1), 32'h3C);
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

      begin
         logic [1:0] ch = 2'd0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) ch = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), ch, ($urandom_range(0, 3) != 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
